// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared constants and types for the 1-to-4 stream demux.
//   NUM_LANES / SEL_W : lane count and lane-select width.
//   lane_state_e      : occupancy state of a one-entry lane register.
package stream_demux_pkg;
  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;

  typedef enum logic {LANE_EMPTY, LANE_FULL} lane_state_e;
endpackage

// File: rtl/demux_lane_reg.sv
// demux_lane_reg: one-entry register slice for a single demux output lane.
// Optional macro STREAM_DEMUX_BEAT_CNT_EN adds a wrapping per-lane drain counter.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_load    : write in_data into the slot (caller guarantees slot can take it)
//   in_data    : DATA_W payload
//   out_valid  : slot holds a beat
//   out_ready  : downstream accepts the held beat
//   out_data   : held payload (kept after drain, not cleared)
//   beat_cnt   : drained-beat count, 0 when counter is compiled out
import stream_demux_pkg::*;

module demux_lane_reg #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_load,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  beat_cnt
);
  lane_state_e state_q, state_d;
  logic        drain;

  assign out_valid = (state_q == LANE_FULL);
  assign drain     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= LANE_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LANE_EMPTY: if (in_load) state_d = LANE_FULL;
      LANE_FULL:  if (drain && !in_load) state_d = LANE_EMPTY;
      default:    state_d = LANE_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)          out_data <= '0;
    else if (in_load) out_data <= in_data;
  end

`ifdef STREAM_DEMUX_BEAT_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst)        cnt_q <= '0;
    else if (drain) cnt_q <= cnt_q + 1'b1;  // wraps naturally
  end
  assign beat_cnt = cnt_q;
`else
  assign beat_cnt = '0;
`endif
endmodule

// File: rtl/stream_demux_1x4.sv
// stream_demux_1x4: registered 1-to-4 valid/ready stream demultiplexer.
// Each lane is a one-entry slice, so a stalled lane only blocks beats aimed at it.
// Optional macro STREAM_DEMUX_BEAT_CNT_EN enables per-lane beat counters.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   s_valid/s_ready   : input handshake
//   s_data, s_sel     : input payload and destination lane
//   m_valid, m_ready  : per-lane handshake, bit k = lane k
//   m_data            : lane k at [k*DATA_W +: DATA_W]
//   beat_cnt          : lane k at [k*CNT_W +: CNT_W], 0 if feature compiled out
import stream_demux_pkg::*;

module stream_demux_1x4 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_W-1:0]           s_data,
  input  logic [SEL_W-1:0]            s_sel,
  output logic [NUM_LANES-1:0]        m_valid,
  input  logic [NUM_LANES-1:0]        m_ready,
  output logic [NUM_LANES*DATA_W-1:0] m_data,
  output logic [NUM_LANES*CNT_W-1:0]  beat_cnt
);
  logic [NUM_LANES-1:0] load;

  // Selected lane can take a beat if empty or draining this cycle.
  assign s_ready = !rst && (!m_valid[s_sel] || m_ready[s_sel]);

  genvar k;
  generate
    for (k = 0; k < NUM_LANES; k++) begin : g_lane
      assign load[k] = s_valid && s_ready && (s_sel == SEL_W'(k));

      demux_lane_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_lane (
        .clk       (clk),
        .rst       (rst),
        .in_load   (load[k]),
        .in_data   (s_data),
        .out_valid (m_valid[k]),
        .out_ready (m_ready[k]),
        .out_data  (m_data[k*DATA_W +: DATA_W]),
        .beat_cnt  (beat_cnt[k*CNT_W +: CNT_W])
      );
    end
  endgenerate
endmodule

// File: tb/tb_stream_demux_1x4.sv
module tb_stream_demux_1x4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [7:0]    s_data;
  logic [1:0]    s_sel;
  logic [3:0]    m_valid;
  logic [3:0]    m_ready;
  logic [31:0]   m_data;
  logic [15:0]   beat_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_demux_1x4 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_sel(s_sel), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .beat_cnt(beat_cnt)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b1; s_sel = 2'd0; s_data = 8'hFF; m_ready = 4'b0000;
    tick(); tick();
    checks++;
    if (m_valid !== 4'b0000) begin failures++; $display("FAIL reset_m_valid got=%b exp=0000", m_valid); end
    checks++;
    if (m_data !== 32'h0) begin failures++; $display("FAIL reset_m_data got=%h exp=00000000", m_data); end
    checks++;
    if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
    checks++;
    if (beat_cnt !== 16'h0) begin failures++; $display("FAIL reset_beat_cnt got=%h exp=0000", beat_cnt); end
    rst = 1'b0; s_valid = 1'b0; #1;
    checks++;
    if (s_ready !== 1'b1) begin failures++; $display("FAIL post_reset_s_ready got=%b exp=1", s_ready); end
  endtask

  task automatic test_routing();
    logic [3:0] expv;
    m_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_sel = 2'(i); s_data = 8'h10 + 8'(i); #1;
      checks++;
      if (s_ready !== 1'b1) begin failures++; $display("FAIL route_s_ready lane=%0d got=%b exp=1", i, s_ready); end
      tick();
      expv = 4'b0001 << i;
      checks++;
      if (m_valid !== expv) begin failures++; $display("FAIL route_m_valid lane=%0d got=%b exp=%b", i, m_valid, expv); end
      checks++;
      if (m_data[i*8 +: 8] !== 8'h10 + 8'(i)) begin
        failures++; $display("FAIL route_m_data lane=%0d got=%h exp=%h", i, m_data[i*8 +: 8], 8'h10 + 8'(i));
      end
    end
    s_valid = 1'b0;
    tick();
    checks++;
    if (m_valid !== 4'b0000) begin failures++; $display("FAIL route_idle_m_valid got=%b exp=0000", m_valid); end
    checks++;
    if (m_data !== 32'h13121110) begin failures++; $display("FAIL route_data_held got=%h exp=13121110", m_data); end
  endtask

  task automatic test_backpressure();
    m_ready = 4'b1110;
    s_valid = 1'b1; s_sel = 2'd0; s_data = 8'hA0;
    tick();
    s_data = 8'hA1; #1;
    checks++;
    if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_s_ready_blocked got=%b exp=0", s_ready); end
    tick();
    checks++;
    if (m_valid !== 4'b0001 || m_data[7:0] !== 8'hA0) begin
      failures++; $display("FAIL bp_lane0_hold got=%b/%h exp=0001/a0", m_valid, m_data[7:0]);
    end
    s_sel = 2'd2; s_data = 8'hB2; #1;
    checks++;
    if (s_ready !== 1'b1) begin failures++; $display("FAIL bp_lane2_ready got=%b exp=1", s_ready); end
    tick();
    checks++;
    if (m_valid !== 4'b0101 || m_data[23:16] !== 8'hB2 || m_data[7:0] !== 8'hA0) begin
      failures++; $display("FAIL bp_lane2_load got=%b/%h exp=0101/b2..a0", m_valid, m_data);
    end
    s_sel = 2'd0; s_data = 8'hA1; m_ready = 4'b1111; #1;
    checks++;
    if (s_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", s_ready); end
    tick();
    checks++;
    if (m_valid !== 4'b0001 || m_data[7:0] !== 8'hA1) begin
      failures++; $display("FAIL bp_a1_load got=%b/%h exp=0001/a1", m_valid, m_data[7:0]);
    end
    s_valid = 1'b0;
    tick();
    checks++;
    if (m_valid !== 4'b0000) begin failures++; $display("FAIL bp_drain got=%b exp=0000", m_valid); end
  endtask

  task automatic test_simul_drain_load();
    m_ready = 4'b0000;
    s_valid = 1'b1; s_sel = 2'd1; s_data = 8'h55;
    tick();
    checks++;
    if (m_valid !== 4'b0010 || m_data[15:8] !== 8'h55) begin
      failures++; $display("FAIL sim_load55 got=%b/%h exp=0010/55", m_valid, m_data[15:8]);
    end
    m_ready = 4'b0010; s_data = 8'h66; #1;
    checks++;
    if (s_ready !== 1'b1) begin failures++; $display("FAIL sim_s_ready got=%b exp=1", s_ready); end
    tick();
    checks++;
    if (m_valid !== 4'b0010 || m_data[15:8] !== 8'h66) begin
      failures++; $display("FAIL sim_load66 got=%b/%h exp=0010/66", m_valid, m_data[15:8]);
    end
    s_valid = 1'b0;
    tick();
    checks++;
    if (m_valid !== 4'b0000) begin failures++; $display("FAIL sim_drain got=%b exp=0000", m_valid); end
  endtask

  task automatic test_cnt_before_reset();
    logic [15:0] exp;
`ifdef STREAM_DEMUX_BEAT_CNT_EN
    // drains so far: lane0 3, lane1 3, lane2 2, lane3 1
    exp = 16'h1233;
`else
    exp = 16'h0000;
`endif
    checks++;
    if (beat_cnt !== exp) begin failures++; $display("FAIL cnt_mid got=%h exp=%h", beat_cnt, exp); end
  endtask

  task automatic test_reset_mid();
    m_ready = 4'b0000;
    s_valid = 1'b1; s_sel = 2'd0; s_data = 8'hC0;
    tick();
    s_sel = 2'd3; s_data = 8'hC3;
    tick();
    checks++;
    if (m_valid !== 4'b1001) begin failures++; $display("FAIL mid_full got=%b exp=1001", m_valid); end
    s_valid = 1'b0; rst = 1'b1; #1;
    checks++;
    if (s_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_s_ready got=%b exp=0", s_ready); end
    tick();
    checks++;
    if (m_valid !== 4'b0000) begin failures++; $display("FAIL mid_rst_m_valid got=%b exp=0000", m_valid); end
    checks++;
    if (beat_cnt !== 16'h0) begin failures++; $display("FAIL mid_rst_cnt got=%h exp=0000", beat_cnt); end
    rst = 1'b0; m_ready = 4'b1111;
    tick();
    checks++;
    if (m_valid !== 4'b0000) begin failures++; $display("FAIL mid_after_rst got=%b exp=0000", m_valid); end
  endtask

  task automatic test_counter_wrap();
    logic [15:0] exp;
    m_ready = 4'b1111;
    for (int i = 0; i < 17; i++) begin
      s_valid = 1'b1; s_sel = 2'd2; s_data = 8'(i);
      tick();
    end
    checks++;
    if (m_valid !== 4'b0100 || m_data[23:16] !== 8'd16) begin
      failures++; $display("FAIL wrap_last_beat got=%b/%h exp=0100/10", m_valid, m_data[23:16]);
    end
    s_valid = 1'b0;
    tick();
`ifdef STREAM_DEMUX_BEAT_CNT_EN
    exp = 16'h0100;
`else
    exp = 16'h0000;
`endif
    checks++;
    if (beat_cnt !== exp) begin failures++; $display("FAIL wrap_beat_cnt got=%h exp=%h", beat_cnt, exp); end
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_sel = '0; m_ready = '0;
    test_reset();
    test_routing();
    test_backpressure();
    test_simul_drain_load();
    test_cnt_before_reset();
    test_reset_mid();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stream_demux_1x4.md
Name: stream_demux_1x4

Overview:
- Registered 1-to-4 stream demultiplexer; the write-side counterpart of the 4x1 read-data mux.
- Routes one valid/ready input beat to one of four output lanes selected by s_sel.
- Each lane holds one entry, so backpressure on one lane does not stall the other lanes.
- Sits between the AXI slave front-end and the per-bank / per-port write paths of the dual-port RAM.

Parameters:
- DATA_W, 8, width of each data beat.
- CNT_W, 16, width of each per-lane beat counter (optional feature only).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- s_valid  input  1  input beat valid.
- s_ready  output  1  input beat accepted when s_valid && s_ready.
- s_data  input  DATA_W  input beat payload.
- s_sel  input  2  destination lane, 0..3; sampled only when s_valid=1.
- m_valid  output  4  per-lane valid; bit k = lane k.
- m_ready  input  4  per-lane ready; bit k = lane k.
- m_data  output  4*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].
- beat_cnt  output  4*CNT_W  lane k count in bits [k*CNT_W +: CNT_W]; reads 0 when feature compiled out.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst); polarity and synchronicity are fixed.
- Reset values: m_valid=4'b0000, m_data=0, beat_cnt=0, all lanes in LANE_EMPTY. While rst=1, s_ready=0.
- Each lane is a two-state machine, LANE_EMPTY and LANE_FULL:
  - EMPTY -> FULL on a load.
  - FULL -> EMPTY on a drain with no load in the same cycle.
  - FULL -> FULL when a load and a drain happen in the same cycle.
- Definitions for lane k:
  - load[k] = s_valid && s_ready && (s_sel == k)
  - drain[k] = m_valid[k] && m_ready[k]
- s_ready = (lane s_sel is EMPTY) || m_ready[s_sel].
  - s_ready is combinational from s_sel and m_ready, with no other combinational path.
  - There is no dependence on s_valid.
- Latency: a beat accepted at edge N appears on m_data/m_valid of lane s_sel after edge N, so it is visible in cycle N+1.
- Load: m_data lane k <= s_data and m_valid[k] <= 1. The other lanes are unaffected.
- Drain without load: m_valid[k] <= 0 and m_data holds its last value (it is not cleared).
- Output stability: while m_valid[k]=1 && m_ready[k]=0, lane k data and valid are held constant.
- Lanes are independent. A full, stalled lane only blocks input beats addressed to that lane. There is no head-of-line blocking beyond the single input beat currently presented.
- Beat order is preserved within a lane. There is no ordering relation between lanes.
- When s_valid=0, s_sel and s_data are don't-care and no lane state changes.
- Reset mid-operation discards all held beats. m_valid drops on the edge where rst is sampled high.
- No beat is ever dropped or duplicated outside reset.

Optional Feature:
- Macro: STREAM_DEMUX_BEAT_CNT_EN.
- Defined:
  - Each lane has a CNT_W-bit counter that increments on drain[k] and wraps from 2^CNT_W-1 to 0.
  - Counters reset to 0.
  - The counter value is driven on beat_cnt.
- Undefined: no counter flops are built and beat_cnt is tied to 0.
- The handshake and data path are identical in both builds.

Decomposition:
- Package stream_demux_pkg holds:
  - NUM_LANES = 4 and SEL_W = 2.
  - typedef enum logic {LANE_EMPTY, LANE_FULL} lane_state_e.
- One sub-module, demux_lane_reg:
  - A one-entry register slice with in_load, in_data, out_valid, out_ready and out_data, plus the optional counter.
  - Instantiated NUM_LANES times by a generate loop.
- The top level holds the s_ready select and the load decode.

Test Plan:
- Reset: hold rst=1 for 2 cycles with s_valid=1 -> m_valid=0000, m_data=0, s_ready=0; after release, s_ready=1.
- Routing: m_ready=1111; send 8'h10, 8'h11, 8'h12, 8'h13 with s_sel=0,1,2,3 on consecutive cycles -> each value appears one cycle later on lanes 0..3 in turn, each with a single-cycle m_valid pulse.
- Backpressure isolation: m_ready=1110; send 8'hA0 to lane 0, then 8'hA1 to lane 0 -> s_ready=0 on the second beat and lane 0 holds 8'hA0. Next send 8'hB2 to lane 2 -> accepted immediately. Then set m_ready[0]=1 -> 8'hA1 loads the cycle after 8'hA0 drains.
- Simultaneous drain and load: lane 1 full with 8'h55 and m_ready[1]=1; send 8'h66 to lane 1 in the same cycle -> m_valid[1] stays 1 and m_data lane 1 becomes 8'h66 with no bubble.
- Reset mid-operation: lanes 0 and 3 full with m_ready=0000; assert rst for 1 cycle -> m_valid=0000 and the held beats are not presented after release.
- With STREAM_DEMUX_BEAT_CNT_EN and CNT_W=4: drain 17 beats on lane 2 -> beat_cnt lane 2 = 1 (wrapped) and the other lanes read 0. Without the macro, beat_cnt is always 0.
